// File: rtl/sequencer_loader_if.sv
// Bundle of the sequencer control strobes and program-loader handshake/bus.
// master drives the control and loader inputs; slave is the sequencer itself.
interface sequencer_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              START;
   logic [3:0]        IR;
   logic              EXTRA;
   logic              LD_VALID;
   logic [3:0]        LD_OP;
   logic [7:0]        LD_OPERAND;
   logic              FETCH;
   logic              EXEC1;
   logic              EXEC2;
   logic              PC_CLR;
   logic              HALTED;
   logic              LD_READY;
   logic              LD_WREN;
   logic [ADDR_W-1:0] LD_ADDR;
   logic [15:0]       LD_DATA;
   logic              LD_ERR;
   logic [ADDR_W:0]   LD_COUNT;

   modport master (
      output START, IR, EXTRA, LD_VALID, LD_OP, LD_OPERAND,
      input  FETCH, EXEC1, EXEC2, PC_CLR, HALTED,
      input  LD_READY, LD_WREN, LD_ADDR, LD_DATA, LD_ERR, LD_COUNT
   );

   modport slave (
      input  START, IR, EXTRA, LD_VALID, LD_OP, LD_OPERAND,
      output FETCH, EXEC1, EXEC2, PC_CLR, HALTED,
      output LD_READY, LD_WREN, LD_ADDR, LD_DATA, LD_ERR, LD_COUNT
   );
endinterface

// File: rtl/sequencer_loader.sv
// Instruction-phase sequencer with a program loader.
// In LOAD, words offered by the loader are validated, encoded and written to
// program memory one cycle after acceptance. START then runs the
// FETCH / EXEC1 / (EXEC2) cycle until an STP opcode parks the machine in HALT.
module sequencer_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input logic              CLK,
   input logic              RESETn,
   sequencer_loader_if.slave bus
);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_FETCH,
      ST_EXEC1,
      ST_EXEC2,
      ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_STA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_JMP = 4'h4,
      OP_JMI = 4'h5,
      OP_JEQ = 4'h6,
      OP_STP = 4'h7,
      OP_LDI = 4'h8,
      OP_LSR = 4'hA,
      OP_ASR = 4'hB
   } opcode_t;

   state_t            state_q, state_d;
   logic              pc_clr;

   logic              ld_ready;
   logic              ld_accept;
   logic              op_legal;
   logic              op_no_operand;
   logic              ld_wren_q, ld_wren_d;
   logic              ld_err_q, ld_err_d;
   logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
   logic [15:0]       ld_data_q, ld_data_d;
   logic [ADDR_W:0]   ld_count_q, ld_count_d;

   // Phase sequencing: next state and the PC_CLR pulse on leaving LOAD/HALT.
   always_comb begin
      state_d = state_q;
      pc_clr  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (bus.START) begin
               state_d = ST_FETCH;
               pc_clr  = 1'b1;
            end
         end
         ST_FETCH: state_d = ST_EXEC1;
         ST_EXEC1: begin
            if (bus.IR == OP_STP) begin
               state_d = ST_HALT;
            end else if (bus.EXTRA) begin
               state_d = ST_EXEC2;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC2: state_d = ST_FETCH;
         ST_HALT: begin
            if (bus.START) begin
               state_d = ST_FETCH;
               pc_clr  = 1'b1;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Phase state register.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Loader handshake: validate, encode and stage the memory write.
   // The top count bit set means every address has been written once.
   always_comb begin
      ld_ready      = (state_q == ST_LOAD) && !ld_count_q[ADDR_W];
      ld_accept     = bus.LD_VALID && ld_ready;
      op_legal      = !(bus.LD_OP inside {4'h9, [4'hC:4'hF]});
      op_no_operand = bus.LD_OP inside {OP_STP, OP_LSR, OP_ASR};
      ld_wren_d     = ld_accept && op_legal;
      ld_err_d      = ld_accept && !op_legal;
      ld_addr_d     = ld_addr_q;
      ld_data_d     = ld_data_q;
      ld_count_d    = ld_count_q;
      if (ld_wren_d) begin
         ld_addr_d  = ld_count_q[ADDR_W-1:0];
         ld_data_d  = {bus.LD_OP, 4'h0, op_no_operand ? 8'h00 : bus.LD_OPERAND};
         ld_count_d = ld_count_q + (ADDR_W+1)'(1);
      end
   end

   // Loader registers; reset discards any write staged in the same cycle.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         ld_wren_q  <= 1'b0;
         ld_err_q   <= 1'b0;
         ld_addr_q  <= '0;
         ld_data_q  <= '0;
         ld_count_q <= '0;
      end else begin
         ld_wren_q  <= ld_wren_d;
         ld_err_q   <= ld_err_d;
         ld_addr_q  <= ld_addr_d;
         ld_data_q  <= ld_data_d;
         ld_count_q <= ld_count_d;
      end
   end

   assign bus.FETCH    = (state_q == ST_FETCH);
   assign bus.EXEC1    = (state_q == ST_EXEC1);
   assign bus.EXEC2    = (state_q == ST_EXEC2);
   assign bus.HALTED   = (state_q == ST_HALT);
   assign bus.PC_CLR   = pc_clr;
   assign bus.LD_READY = ld_ready;
   assign bus.LD_WREN  = ld_wren_q;
   assign bus.LD_ERR   = ld_err_q;
   assign bus.LD_ADDR  = ld_addr_q;
   assign bus.LD_DATA  = ld_data_q;
   assign bus.LD_COUNT = ld_count_q;

endmodule

// File: tb/tb_sequencer_loader.sv
// Bench for sequencer_loader: a 256-word and a 4-word instance share one
// stimulus stream; both are compared every cycle against a phase/loader model,
// and the large instance additionally against a hand-written vector table.
module tb_sequencer_loader;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start, extra, vld;
   logic [3:0] ir, op;
   logic [7:0] opd;

   always #5 clk = ~clk;

   sequencer_loader_if #(.ADDR_W(8)) if8 ();
   sequencer_loader_if #(.ADDR_W(2)) if2 ();

   sequencer_loader #(.ADDR_W(8)) dut8 (.CLK(clk), .RESETn(rstn), .bus(if8));
   sequencer_loader #(.ADDR_W(2)) dut2 (.CLK(clk), .RESETn(rstn), .bus(if2));

   assign if8.START = start;  assign if2.START = start;
   assign if8.IR = ir;        assign if2.IR = ir;
   assign if8.EXTRA = extra;  assign if2.EXTRA = extra;
   assign if8.LD_VALID = vld; assign if2.LD_VALID = vld;
   assign if8.LD_OP = op;     assign if2.LD_OP = op;
   assign if8.LD_OPERAND = opd; assign if2.LD_OPERAND = opd;

   int checks = 0;
   int errors = 0;

   // Reference model: phase by name, loader as a word count per instance.
   string       m_ph;
   int          m_cnt  [2];
   bit          m_wr   [2];
   int          m_addr [2];
   logic [15:0] m_data [2];
   bit          m_err  [2];
   int          depth  [2] = '{256, 4};

   typedef struct {
      logic rn, st; logic [3:0] ir; logic ex, vl; logic [3:0] op; logic [7:0] od;
      logic fe, e1, e2, pc, ha, rd, we, er; logic [15:0] ad, da; logic [8:0] cn;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rn, st, input logic [3:0] ir_i, input logic ex, vl,
                               input logic [3:0] op_i, input logic [7:0] od,
                               input logic fe, e1, e2, pc, ha, rd, we, er,
                               input logic [15:0] ad, da, input logic [8:0] cn);
      vec_t v;
      v.rn = rn; v.st = st; v.ir = ir_i; v.ex = ex; v.vl = vl; v.op = op_i; v.od = od;
      v.fe = fe; v.e1 = e1; v.e2 = e2; v.pc = pc; v.ha = ha; v.rd = rd; v.we = we; v.er = er;
      v.ad = ad; v.da = da; v.cn = cn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rn, st, input logic [3:0] ir_i, input logic ex, vl,
                        input logic [3:0] op_i, input logic [7:0] od);
      rstn = rn; start = st; ir = ir_i; extra = ex; vld = vl; op = op_i; opd = od;
   endtask

   task automatic check_inst(input int d, input string tag,
                             input logic fe, e1, e2, pc, ha, rd, we,
                             input logic [31:0] ad, input logic [15:0] da,
                             input logic er, input logic [31:0] cn);
      chk({tag, ".FETCH"},  fe, m_ph == "FETCH");
      chk({tag, ".EXEC1"},  e1, m_ph == "EXEC1");
      chk({tag, ".EXEC2"},  e2, m_ph == "EXEC2");
      chk({tag, ".HALTED"}, ha, m_ph == "HALT");
      chk({tag, ".PC_CLR"}, pc, ((m_ph == "LOAD") || (m_ph == "HALT")) && start);
      chk({tag, ".LD_READY"}, rd, (m_ph == "LOAD") && (m_cnt[d] < depth[d]));
      chk({tag, ".LD_WREN"}, we, m_wr[d]);
      if (m_wr[d]) begin
         chk({tag, ".LD_ADDR"}, ad, m_addr[d]);
         chk({tag, ".LD_DATA"}, da, m_data[d]);
      end
      chk({tag, ".LD_ERR"}, er, m_err[d]);
      chk({tag, ".LD_COUNT"}, cn, m_cnt[d]);
   endtask

   task automatic model_update();
      bit legal, zop, acc;
      if (!rstn) begin
         m_ph = "LOAD";
         for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_wr[d] = 0; m_err[d] = 0;
         end
         return;
      end
      legal = !(op == 4'd9 || op >= 4'd12);
      zop   = (op == 4'd7) || (op == 4'd10) || (op == 4'd11);
      for (int d = 0; d < 2; d++) begin
         acc      = vld && (m_ph == "LOAD") && (m_cnt[d] < depth[d]);
         m_wr[d]  = acc && legal;
         m_err[d] = acc && !legal;
         if (m_wr[d]) begin
            m_addr[d] = m_cnt[d];
            m_data[d] = {op, 4'h0, zop ? 8'h00 : opd};
            m_cnt[d]  = m_cnt[d] + 1;
         end
      end
      if (((m_ph == "LOAD") || (m_ph == "HALT")) && start) m_ph = "FETCH";
      else if (m_ph == "FETCH") m_ph = "EXEC1";
      else if (m_ph == "EXEC1") begin
         if (ir == 4'd7)  m_ph = "HALT";
         else if (extra)  m_ph = "EXEC2";
         else             m_ph = "FETCH";
      end
      else if (m_ph == "EXEC2") m_ph = "FETCH";
   endtask

   // Sample both instances mid-cycle against the model.
   task automatic sample_half();
      @(negedge clk);
      check_inst(0, "w256", if8.FETCH, if8.EXEC1, if8.EXEC2, if8.PC_CLR, if8.HALTED,
                 if8.LD_READY, if8.LD_WREN, 32'(if8.LD_ADDR), if8.LD_DATA, if8.LD_ERR,
                 32'(if8.LD_COUNT));
      check_inst(1, "w4", if2.FETCH, if2.EXEC1, if2.EXEC2, if2.PC_CLR, if2.HALTED,
                 if2.LD_READY, if2.LD_WREN, 32'(if2.LD_ADDR), if2.LD_DATA, if2.LD_ERR,
                 32'(if2.LD_COUNT));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      model_update();
      #1;

      //          rn st ir ex vl op  od     fe e1 e2 pc ha rd we er ad  da        cn
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 8'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 2, 8'h11, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0010, 1));
      tbl.push_back(mk(1, 0, 0, 0, 1, 7, 8'hFF, 0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h2011, 2));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 2, 16'h7000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 1, 9, 8'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 7, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 8'h03, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 0, 0, 1, 8, 8'h5A, 0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h805A, 1));
      tbl.push_back(mk(1, 0, 0, 0, 1, 3, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1));

      foreach (tbl[i]) begin
         drive(tbl[i].rn, tbl[i].st, tbl[i].ir, tbl[i].ex, tbl[i].vl, tbl[i].op, tbl[i].od);
         sample_half();
         chk($sformatf("vec%0d.FETCH", i),    if8.FETCH,    tbl[i].fe);
         chk($sformatf("vec%0d.EXEC1", i),    if8.EXEC1,    tbl[i].e1);
         chk($sformatf("vec%0d.EXEC2", i),    if8.EXEC2,    tbl[i].e2);
         chk($sformatf("vec%0d.PC_CLR", i),   if8.PC_CLR,   tbl[i].pc);
         chk($sformatf("vec%0d.HALTED", i),   if8.HALTED,   tbl[i].ha);
         chk($sformatf("vec%0d.LD_READY", i), if8.LD_READY, tbl[i].rd);
         chk($sformatf("vec%0d.LD_WREN", i),  if8.LD_WREN,  tbl[i].we);
         chk($sformatf("vec%0d.LD_ERR", i),   if8.LD_ERR,   tbl[i].er);
         chk($sformatf("vec%0d.LD_COUNT", i), 32'(if8.LD_COUNT), 32'(tbl[i].cn));
         if (tbl[i].we) begin
            chk($sformatf("vec%0d.LD_ADDR", i), 32'(if8.LD_ADDR), 32'(tbl[i].ad));
            chk($sformatf("vec%0d.LD_DATA", i), 32'(if8.LD_DATA), 32'(tbl[i].da));
         end
         advance();
      end

      // Random traffic, including resets mid-load and mid-execution.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 7) == 0) ? 4'd7 : 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)));
         sample_half();
         advance();
      end

      // Fill the 4-word instance: fifth offered word must not be written.
      drive(0, 0, 0, 0, 0, 0, 8'h00);
      sample_half();
      advance();
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, 0, 0, (k < 5), 4'd0, 8'(8'h40 + k));
         sample_half();
         if (k == 4) begin
            chk("full.LD_READY", if2.LD_READY, 1'b0);
            chk("full.LD_COUNT", 32'(if2.LD_COUNT), 32'd4);
            chk("full.LD_ADDR",  32'(if2.LD_ADDR), 32'd3);
         end
         if (k == 5) begin
            chk("full.no_fifth_write", if2.LD_WREN, 1'b0);
            chk("full.count_held", 32'(if2.LD_COUNT), 32'd4);
            chk("big.LD_COUNT", 32'(if8.LD_COUNT), 32'd5);
         end
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
